// File: rtl/synth_pkg.sv
// Shared types and constants for the note envelope synthesizer.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_e;

    localparam int AMP_MAX = 255;
    localparam int WAVE_W  = 8;
    localparam int KEY_W   = 17;

endpackage

// File: rtl/sine_rom.sv
// 64x8 signed sine table, round(127*sin(2*pi*p/64)), with one registered read.
module sine_rom
    import synth_pkg::*;
(
    input  logic                     clk,
    input  logic [5:0]               addr,
    output logic signed [WAVE_W-1:0] data
);

    localparam logic signed [WAVE_W-1:0] TABLE [64] = '{
          8'sd0,    8'sd12,   8'sd25,   8'sd37,   8'sd49,   8'sd60,   8'sd71,   8'sd81,
          8'sd90,   8'sd98,   8'sd106,  8'sd112,  8'sd117,  8'sd122,  8'sd125,  8'sd126,
          8'sd127,  8'sd126,  8'sd125,  8'sd122,  8'sd117,  8'sd112,  8'sd106,  8'sd98,
          8'sd90,   8'sd81,   8'sd71,   8'sd60,   8'sd49,   8'sd37,   8'sd25,   8'sd12,
          8'sd0,   -8'sd12,  -8'sd25,  -8'sd37,  -8'sd49,  -8'sd60,  -8'sd71,  -8'sd81,
         -8'sd90,  -8'sd98,  -8'sd106, -8'sd112, -8'sd117, -8'sd122, -8'sd125, -8'sd126,
         -8'sd127, -8'sd126, -8'sd125, -8'sd122, -8'sd117, -8'sd112, -8'sd106, -8'sd98,
         -8'sd90,  -8'sd81,  -8'sd71,  -8'sd60,  -8'sd49,  -8'sd37,  -8'sd25,  -8'sd12
    };

    always_ff @(posedge clk) begin
        data <= TABLE[addr];
    end

endmodule

// File: rtl/note_envelope_synth.sv
// Envelope-scaled waveform synthesizer driven by the note-rate ready pulses.
// SYNTH_SINE_ROM_EN selects the sine ROM; otherwise a computed triangle is used.
module note_envelope_synth
    import synth_pkg::*;
#(
    parameter int PHASE_BITS   = 6,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [KEY_W-1:0]         key_num,
    input  logic                     ready,
    input  logic                     env_tick,
    output logic                     restart,
    output logic signed [WAVE_W-1:0] sample,
    output logic                     sample_valid,
    output logic                     busy
);

    logic [KEY_W-1:0]         key_prev;
    logic [PHASE_BITS-1:0]    phase, phase_next;
    logic [7:0]               amp, amp_next;
    env_state_e               state, state_next;
    logic                     new_note;
    logic                     vld_p0, vld_p1;
    logic signed [WAVE_W-1:0] w_p1;

    function automatic logic [7:0] amp_add(input logic [7:0] a);
        logic [8:0] s;
        s = {1'b0, a} + 9'(ATTACK_STEP);
        return s[8] ? 8'(AMP_MAX) : s[7:0];
    endfunction

    function automatic logic [7:0] amp_sub(input logic [7:0] a);
        return (a < 8'(RELEASE_STEP)) ? 8'd0 : a - 8'(RELEASE_STEP);
    endfunction

    // Product bits [15:8] of a signed multiply floor negative results toward -inf.
    function automatic logic signed [WAVE_W-1:0] scale(input logic signed [WAVE_W-1:0] w,
                                                       input logic [7:0] a);
        logic signed [15:0] we, ae, prod;
        we   = {{8{w[WAVE_W-1]}}, w};
        ae   = {8'd0, a};
        prod = we * ae;
        return prod[15:8];
    endfunction

    assign new_note = (key_num != '0) && (key_num != key_prev);

    always_comb begin
        amp_next = amp;
        if (env_tick) begin
            case (state)
                ATTACK:  amp_next = amp_add(amp);
                RELEASE: amp_next = amp_sub(amp);
                default: amp_next = amp;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        if (new_note) begin
            state_next = ATTACK;
        end else begin
            case (state)
                ATTACK: begin
                    if (key_num == '0)
                        state_next = RELEASE;
                    else if (amp_next == 8'(AMP_MAX))
                        state_next = SUSTAIN;
                end
                SUSTAIN: if (key_num == '0) state_next = RELEASE;
                RELEASE: if (amp_next == 8'd0) state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        phase_next = phase;
        if (new_note || state == IDLE)
            phase_next = '0;
        else if (ready)
            phase_next = phase + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Stage p0: phase step, envelope update and control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev     <= '0;
            phase        <= '0;
            amp          <= '0;
            restart      <= 1'b0;
            busy         <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
        end else begin
            key_prev     <= key_num;
            phase        <= phase_next;
            amp          <= amp_next;
            restart      <= new_note;
            busy         <= (state_next != IDLE);
            vld_p0       <= ready;
            vld_p1       <= vld_p0;
            sample_valid <= vld_p1;
            if (vld_p1)
                sample <= scale(w_p1, amp);
        end
    end

    // Stage p1: waveform lookup from the updated phase
`ifdef SYNTH_SINE_ROM_EN
    sine_rom u_sine_rom (
        .clk  (clk),
        .addr (phase[PHASE_BITS-1 -: 6]),
        .data (w_p1)
    );
`else
    function automatic logic signed [WAVE_W-1:0] tri_wave(input logic [5:0] p);
        logic [7:0] ramp;
        ramp = {p[4:0], 3'b000};
        return p[5] ? $signed(8'd127 - ramp) : $signed(ramp - 8'd128);
    endfunction

    always_ff @(posedge clk) begin
        w_p1 <= tri_wave(phase[PHASE_BITS-1 -: 6]);
    end
`endif

endmodule

// File: tb/tb_note_envelope_synth.sv
// Scoreboard bench for note_envelope_synth (expected samples queued at each ready pulse).
module tb_note_envelope_synth;
    import synth_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [16:0]        key_num = '0;
    logic               ready = 1'b0;
    logic               env_tick = 1'b0;
    logic               restart;
    logic signed [7:0]  sample;
    logic               sample_valid;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;
    int restart_seen = 0;
    int exp_q[$];

    note_envelope_synth dut (
        .clk          (clk),
        .reset        (reset),
        .key_num      (key_num),
        .ready        (ready),
        .env_tick     (env_tick),
        .restart      (restart),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int wave_ref(input int p);
`ifdef SYNTH_SINE_ROM_EN
        return int'(127.0 * $sin(2.0 * 3.141592653589793 * p / 64.0));
`else
        if (p < 32) return 8 * p - 128;
        return 127 - 8 * (p - 32);
`endif
    endfunction

    function automatic int sample_ref(input int p, input int a);
        return (wave_ref(p) * a) >>> 8;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_env(input int n);
        repeat (n) begin
            env_tick = 1'b1;
            step(1);
            env_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic pulse_ready(input int p, input int a);
        exp_q.push_back(sample_ref(p, a));
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        step(1);
    endtask

    always @(negedge clk) begin
        if (restart) restart_seen++;
        if (sample_valid) begin
            check_eq("sample_expected_pending", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0)
                check_eq("sample", int'(sample), exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        step(3);
        reset = 1'b0;
        check_eq("rst_restart", int'(restart), 0);
        check_eq("rst_sample", int'(sample), 0);
        check_eq("rst_sample_valid", int'(sample_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_amp", int'(dut.amp), 0);

        // Idle: strobes still come out, all zero
        for (int i = 0; i < 10; i++) pulse_ready(0, 0);
        step(4);
        check_eq("idle_busy", int'(busy), 0);
        check_eq("idle_restart_count", restart_seen, 0);
        check_eq("idle_queue_drained", exp_q.size(), 0);

        // New note: one-cycle restart, then attack to saturation
        key_num = 17'h10000;
        step(1);
        check_eq("note_restart_hi", int'(restart), 1);
        check_eq("note_busy", int'(busy), 1);
        check_eq("note_state_attack", int'(dut.state), int'(ATTACK));
        step(1);
        check_eq("note_restart_lo", int'(restart), 0);
        tick_env(16);
        check_eq("attack_amp_16", int'(dut.amp), 128);
        check_eq("attack_state_16", int'(dut.state), int'(ATTACK));
        tick_env(16);
        check_eq("attack_amp_sat", int'(dut.amp), 255);
        check_eq("sustain_state", int'(dut.state), int'(SUSTAIN));

        // Triangle sweep at full amplitude, first pulse timed exactly
        exp_q.push_back(sample_ref(1, 255));
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check_eq("lat_phase_n1", int'(dut.phase), 1);
        step(1);
        check_eq("lat_valid_n2", int'(sample_valid), 0);
        step(1);
        check_eq("lat_valid_n3", int'(sample_valid), 1);
        step(1);
        for (int i = 2; i <= 64; i++) pulse_ready(i % 64, 255);
        step(4);
        check_eq("sweep_phase_wrap", int'(dut.phase), 0);
        check_eq("sweep_queue_drained", exp_q.size(), 0);

        // Release all the way to IDLE
        key_num = '0;
        step(1);
        check_eq("release_state", int'(dut.state), int'(RELEASE));
        tick_env(127);
        check_eq("release_amp_127", int'(dut.amp), 1);
        check_eq("release_busy_127", int'(busy), 1);
        tick_env(1);
        check_eq("release_amp_0", int'(dut.amp), 0);
        check_eq("release_state_idle", int'(dut.state), int'(IDLE));
        check_eq("release_busy_0", int'(busy), 0);
        check_eq("restart_count_1", restart_seen, 1);

        // New note and ready together: restart wins over the phase step
        exp_q.push_back(sample_ref(0, 0));
        key_num = 17'h00001;
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check_eq("same_cycle_phase", int'(dut.phase), 0);
        check_eq("same_cycle_restart", int'(restart), 1);
        step(3);
        tick_env(13);
        check_eq("attack_amp_104", int'(dut.amp), 104);

        // env_tick on the release cycle still applies the attack step
        key_num = '0;
        env_tick = 1'b1;
        step(1);
        env_tick = 1'b0;
        check_eq("release_tick_amp", int'(dut.amp), 112);
        check_eq("release_tick_state", int'(dut.state), int'(RELEASE));
        tick_env(6);
        check_eq("release_amp_100", int'(dut.amp), 100);

        // Retrigger during release keeps the amplitude
        key_num = 17'h00002;
        step(1);
        check_eq("retrig_state", int'(dut.state), int'(ATTACK));
        check_eq("retrig_amp_kept", int'(dut.amp), 100);
        tick_env(1);
        check_eq("retrig_amp_step", int'(dut.amp), 108);
        tick_env(19);
        check_eq("retrig_amp_sat", int'(dut.amp), 255);
        check_eq("retrig_sustain", int'(dut.state), int'(SUSTAIN));
        check_eq("restart_count_3", restart_seen, 3);

        // Reset mid-SUSTAIN with a sample in flight
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        reset = 1'b1;
        key_num = '0;
        step(1);
        check_eq("mid_rst_restart", int'(restart), 0);
        check_eq("mid_rst_sample", int'(sample), 0);
        check_eq("mid_rst_sample_valid", int'(sample_valid), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_amp", int'(dut.amp), 0);
        reset = 1'b0;
        step(1);
        check_eq("post_rst_sample_valid", int'(sample_valid), 0);
        step(5);
        check_eq("final_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/note_envelope_synth.md
# note_envelope_synth

Downstream consumer of the note-rate `ready` pulse train. Each `ready` pulse advances a 64-step waveform phase. An attack/sustain/release amplitude envelope, driven by the held key pattern, scales the waveform. The block emits a signed 8-bit audio sample with a valid strobe for the audio output stage, and drives the `restart` pulse back to the pulse generator so each new note starts phase-aligned.

## Interface
- `PHASE_BITS`, 6: phase counter width; 2^PHASE_BITS steps per waveform period.
- `ATTACK_STEP`, 8: amplitude increment per `env_tick` in ATTACK.
- `RELEASE_STEP`, 2: amplitude decrement per `env_tick` in RELEASE.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `key_num`  in  17  key pattern, same encoding the pulse generator decodes; nonzero means a note is held.
- `ready`  in  1  one-cycle phase-step pulse from the pulse generator.
- `env_tick`  in  1  one-cycle envelope-rate strobe, nominally 1 kHz.
- `restart`  out  1  one-cycle pulse telling the pulse generator to zero its divider counter.
- `sample`  out  8  signed audio sample.
- `sample_valid`  out  1  one-cycle strobe marking a new `sample`.
- `busy`  out  1  high whenever the envelope state is not IDLE.

## Operation
- Registered state: `key_prev` (17 bits), `phase` (PHASE_BITS), `amp` (8-bit unsigned), `state` ∈ {IDLE, ATTACK, SUSTAIN, RELEASE}.
- A new note is detected when `key_num != 0` and `key_num != key_prev`. `key_prev <= key_num` every cycle.
- On a new note:
  - `restart <= 1` for one cycle.
  - `phase <= 0`.
  - `state <= ATTACK`, entered from any state; `amp` is kept, not zeroed, to avoid clicks.
- State transitions:
  - ATTACK → SUSTAIN when `amp` reaches 255.
  - ATTACK or SUSTAIN → RELEASE when `key_num == 0`.
  - RELEASE → IDLE when `amp` reaches 0.
  - RELEASE → ATTACK only through a new note.
- Envelope, on `env_tick` only:
  - ATTACK: `amp += ATTACK_STEP`, saturating at 255.
  - RELEASE: `amp -= RELEASE_STEP`, saturating at 0.
  - SUSTAIN and IDLE: `amp` holds.
  - The step uses the state held at the start of that cycle.
- Phase:
  - `ready` increments `phase` modulo 2^PHASE_BITS, so 63 wraps to 0.
  - In IDLE, `phase` is held at 0.
  - When a new note and `ready` occur in the same cycle, restart wins and `phase` becomes 0.
- Waveform `w`: signed 8-bit, indexed by the top 6 phase bits; source selected by the configuration macro.
- Scaling: 16-bit signed product `w * $signed({1'b0, amp})`; `sample` is product bits [15:8] (arithmetic shift).
  - `amp = 0` gives `sample = 0`.
  - Negative products round toward −∞.
- Reset values: `restart`, `sample`, `sample_valid`, `busy` = 0; `phase` = 0; `amp` = 0; `key_prev` = 0; `state` = IDLE.

## Timing
- `ready` high in cycle N → `phase` updated at edge N+1 → `w` registered at N+2 → `sample` and `sample_valid` registered at N+3. `sample_valid` is high only in that cycle.
- New note visible on `key_num` in cycle N → `restart` high in cycle N+1 only.
- The pulse generator therefore zeros its counter one cycle after the key change.
- `busy` is registered and follows `state` with zero extra latency.
- `ready` pulses continue in IDLE; they still produce `sample_valid` strobes, with `sample = 0`.
- A reset asserted mid-note forces all reset values at the next edge; in-flight samples are discarded, and `sample_valid` is 0 on the cycle after reset.

## Configuration
- `SYNTH_SINE_ROM_EN` defined: `w` comes from a 64-entry signed sine table, `round(127·sin(2π·p/64))`, one registered read.
- Undefined: `w` is a computed triangle with identical latency, no ROM:
  - `p[5] == 0` → `w = (p[4:0] << 3) − 128`.
  - `p[5] == 1` → `w = 127 − (p[4:0] << 3)`.

## Structure
- Shared package `synth_pkg`: envelope state enum, `AMP_MAX = 255`, `WAVE_W = 8`, `KEY_W = 17`.
- One sub-module, `sine_rom`: 64×8 synchronous ROM, instantiated only under `SYNTH_SINE_ROM_EN`.
- Envelope FSM, phase counter and multiplier stay in the top module.

## Test plan
- Reset, then hold `key_num = 0` and pulse `ready` 10× → `sample = 0` on every strobe, `busy = 0`, `restart` never high.
- Step `key_num` 0 → 17'h10000 → `restart` high for exactly one cycle one cycle later; state ATTACK; after 32 `env_tick`s `amp` = 255 (8·32 = 256, saturated) and state is SUSTAIN.
- In SUSTAIN, triangle build: 64 `ready` pulses → samples trace the triangle, ending at phase wrap 63→0. Phase 0 gives `sample = −128·255>>8 = −128`; phase 32 gives 126. Each sample arrives 3 cycles after its `ready`.
- Release `key_num` to 0 → 128 `env_tick`s bring `amp` to 0, then state is IDLE and `busy` = 0. Pressing a new key at `amp` = 100 during RELEASE → ATTACK resumes from 100.
- Drive a new note and `ready` in the same cycle → `phase` = 0, not 1. Drive `env_tick` in the same cycle as the key release → the ATTACK step is applied, then RELEASE begins.
- Assert `reset` mid-SUSTAIN → all outputs and `amp` = 0 at the next edge, and no `sample_valid` in the following cycle.
